// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank: FSM states, bus geometry,
// the commit-register offset and the byte-lane merge used by every slot.
package opb_regbank_pkg;

  localparam int BUS_W     = 32;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    DONE
  } state_t;

  // Byte offset from the base address at which the commit register lives.
  function automatic logic [BUS_W-1:0] commit_offset(input int num_regs);
    return BUS_W'(num_regs * NUM_LANES);
  endfunction

  function automatic logic [BUS_W-1:0] be_merge(input logic [BUS_W-1:0]     old_val,
                                                input logic [BUS_W-1:0]     new_val,
                                                input logic [NUM_LANES-1:0] be);
    logic [BUS_W-1:0] res;
    res = old_val;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/opb_regbank_slot.sv
// One software-to-fabric register with byte-enable merge. With OPB_REGBANK_COMMIT_EN
// defined, writes land in a shadow and only reach the output on a commit.
module opb_regbank_slot
  import opb_regbank_pkg::*;
#(
  parameter logic [BUS_W-1:0] C_RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [NUM_LANES-1:0] be,
  input  logic [BUS_W-1:0]     wdata,
  input  logic                 commit,
  output logic [BUS_W-1:0]     q,
  output logic [BUS_W-1:0]     rd_val,
  output logic                 dirty,
  output logic                 update
);

`ifdef OPB_REGBANK_COMMIT_EN
  logic [BUS_W-1:0] shadow;

  // An all-zero byte enable touches nothing, so it must not mark the slot dirty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= C_RESET_VAL;
      q      <= C_RESET_VAL;
      dirty  <= 1'b0;
      update <= 1'b0;
    end else begin
      update <= 1'b0;
      if (wr_en && (|be)) begin
        shadow <= be_merge(shadow, wdata, be);
        dirty  <= 1'b1;
      end else if (commit && dirty) begin
        q      <= shadow;
        update <= 1'b1;
        dirty  <= 1'b0;
      end
    end
  end

  assign rd_val = shadow;
`else
  logic unused_commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= C_RESET_VAL;
      update <= 1'b0;
    end else begin
      update <= 1'b0;
      if (wr_en && (|be)) begin
        q      <= be_merge(q, wdata, be);
        update <= 1'b1;
      end
    end
  end

  assign rd_val        = q;
  assign dirty         = 1'b0;
  assign unused_commit = commit;
`endif

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave exposing C_NUM_REGS 32-bit registers to the fabric, one acknowledge per select.
// Define OPB_REGBANK_COMMIT_EN to add shadow registers and a commit register after the last slot.
module opb_register_bank
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR  = 32'h0108F000,
  parameter logic [31:0] C_HIGHADDR  = 32'h0108F0FF,
  parameter int          C_NUM_REGS  = 8,
  parameter logic [31:0] C_RESET_VAL = 32'h00000000
) (
  input  logic                          OPB_Clk,
  input  logic                          OPB_Rst,
  input  logic [0:31]                   OPB_ABus,
  input  logic [0:3]                    OPB_BE,
  input  logic [0:31]                   OPB_DBus,
  input  logic                          OPB_RNW,
  input  logic                          OPB_select,
  input  logic                          OPB_seqAddr,
  output logic [0:31]                   Sl_DBus,
  output logic                          Sl_xferAck,
  output logic                          Sl_errAck,
  output logic                          Sl_retry,
  output logic                          Sl_toutSup,
  output logic [BUS_W*C_NUM_REGS-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]         user_update
);

  state_t                               state, next_state;
  logic                                 in_window;
  logic [BUS_W-1:0]                     offset;
  logic [BUS_W-3:0]                     word_idx;
  logic [NUM_LANES-1:0]                 be;
  logic [BUS_W-1:0]                     wdata;
  logic [BUS_W-1:0]                     rd_word;
  logic                                 wr_strobe;
  logic                                 commit_strobe;
  logic [C_NUM_REGS-1:0][BUS_W-1:0]     slot_rd;
  logic [C_NUM_REGS-1:0]                dirty_mask;
  logic                                 unused_bits;

  // OPB bit 0 is the MSB, so plain assignment puts OPB bit 0 on user bit 31 and BE[0] on lane 3.
  assign be        = OPB_BE;
  assign wdata     = OPB_DBus;
  assign in_window = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign offset    = OPB_ABus - C_BASEADDR;
  assign word_idx  = offset[BUS_W-1:2];

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign Sl_xferAck = (state == ACK);
  assign wr_strobe  = (state == ACK) && !OPB_RNW && in_window;

`ifdef OPB_REGBANK_COMMIT_EN
  logic commit_hit;
  assign commit_hit    = in_window && ({word_idx, 2'b00} == commit_offset(C_NUM_REGS));
  assign commit_strobe = wr_strobe && commit_hit;
  assign unused_bits   = ^{OPB_seqAddr, offset[1:0]};
`else
  assign commit_strobe = 1'b0;
  assign unused_bits   = ^{OPB_seqAddr, offset[1:0], dirty_mask};
`endif

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) state <= IDLE;
    else          state <= next_state;
  end

  // DONE absorbs a held select so a long select never earns a second acknowledge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (OPB_select && in_window) next_state = ACK;
      ACK:     next_state = DONE;
      DONE:    if (!OPB_select) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (in_window && (word_idx == 30'(i))) rd_word = slot_rd[i];
    end
`ifdef OPB_REGBANK_COMMIT_EN
    if (commit_hit) rd_word = BUS_W'(dirty_mask);
`endif
  end

  // Read data is captured on entry to ACK and forced back to zero on the following edge.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst)
      Sl_DBus <= '0;
    else if ((state == IDLE) && (next_state == ACK) && OPB_RNW)
      Sl_DBus <= rd_word;
    else
      Sl_DBus <= '0;
  end

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_slot
    opb_regbank_slot #(
      .C_RESET_VAL (C_RESET_VAL)
    ) u_slot (
      .clk    (OPB_Clk),
      .rst_n  (OPB_Rst),
      .wr_en  (wr_strobe && (word_idx == 30'(i))),
      .be     (be),
      .wdata  (wdata),
      .commit (commit_strobe),
      .q      (user_data_out[BUS_W*i +: BUS_W]),
      .rd_val (slot_rd[i]),
      .dirty  (dirty_mask[i]),
      .update (user_update[i])
    );
  end

endmodule

// File: tb/tb_opb_register_bank.sv
// Directed, table-driven bench for opb_register_bank; the vector table switches with
// OPB_REGBANK_COMMIT_EN, followed by a hand-written reset-abort sequence.
module tb_opb_register_bank;

  localparam logic [31:0] BASE = 32'h0108F000;
  localparam logic [31:0] HIGH = 32'h0108F0FF;

  logic          OPB_Clk;
  logic          OPB_Rst;
  logic [0:31]   OPB_ABus;
  logic [0:3]    OPB_BE;
  logic [0:31]   OPB_DBus;
  logic          OPB_RNW;
  logic          OPB_select;
  logic          OPB_seqAddr;
  logic [0:31]   Sl_DBus;
  logic          Sl_xferAck;
  logic          Sl_errAck;
  logic          Sl_retry;
  logic          Sl_toutSup;
  logic [255:0]  user_data_out;
  logic [7:0]    user_update;

  typedef struct {
    string       name;
    logic        rnw;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    int          hold;
    int          exp_ack;
    logic [31:0] exp_rd;
    logic [7:0]  exp_upd;
    int          word;
    logic [31:0] exp_word;
  } vec_t;

  vec_t        vecs[$];
  int          passed;
  int          total;
  int          ack_cnt;
  int          dbus_bad;
  logic [31:0] rd_data;
  logic [7:0]  upd_at2;
  logic [7:0]  upd_other;

  opb_register_bank dut (
    .OPB_Clk       (OPB_Clk),
    .OPB_Rst       (OPB_Rst),
    .OPB_ABus      (OPB_ABus),
    .OPB_BE        (OPB_BE),
    .OPB_DBus      (OPB_DBus),
    .OPB_RNW       (OPB_RNW),
    .OPB_select    (OPB_select),
    .OPB_seqAddr   (OPB_seqAddr),
    .Sl_DBus       (Sl_DBus),
    .Sl_xferAck    (Sl_xferAck),
    .Sl_errAck     (Sl_errAck),
    .Sl_retry      (Sl_retry),
    .Sl_toutSup    (Sl_toutSup),
    .user_data_out (user_data_out),
    .user_update   (user_update)
  );

  initial OPB_Clk = 1'b0;
  always #5 OPB_Clk = ~OPB_Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    else
      passed++;
  endtask

  task automatic addVec(input string name, input logic rnw, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data, input int hold,
                        input int exp_ack, input logic [31:0] exp_rd, input logic [7:0] exp_upd,
                        input int word, input logic [31:0] exp_word);
    vec_t v;
    v.name = name; v.rnw = rnw; v.addr = addr; v.be = be; v.data = data; v.hold = hold;
    v.exp_ack = exp_ack; v.exp_rd = exp_rd; v.exp_upd = exp_upd; v.word = word; v.exp_word = exp_word;
    vecs.push_back(v);
  endtask

  // One bus transfer starting just after a falling edge; select is held for 'hold' rising edges.
  task automatic applyStimulus(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] data, input int hold);
    ack_cnt   = 0;
    dbus_bad  = 0;
    rd_data   = '0;
    upd_at2   = '0;
    upd_other = '0;
    OPB_RNW    = rnw;
    OPB_ABus   = addr;
    OPB_BE     = be;
    OPB_DBus   = data;
    OPB_select = 1'b1;
    for (int c = 1; c <= hold + 1; c++) begin
      @(negedge OPB_Clk);
      if (Sl_xferAck) begin
        ack_cnt++;
        rd_data = Sl_DBus;
      end else if (Sl_DBus !== '0) begin
        dbus_bad++;
      end
      if (c == 2) upd_at2 = user_update;
      else        upd_other = upd_other | user_update;
      if (c == hold) begin
        OPB_select = 1'b0;
        OPB_ABus   = '0;
        OPB_RNW    = 1'b0;
        OPB_BE     = '0;
        OPB_DBus   = '0;
      end
    end
  endtask

  initial begin
    passed      = 0;
    total       = 0;
    OPB_Rst     = 1'b0;
    OPB_ABus    = '0;
    OPB_BE      = '0;
    OPB_DBus    = '0;
    OPB_RNW     = 1'b0;
    OPB_select  = 1'b0;
    OPB_seqAddr = 1'b0;

`ifdef OPB_REGBANK_COMMIT_EN
    addVec("c_wr_reg0",   1'b0, BASE + 32'h00, 4'b1111, 32'h00000001, 2, 1, 32'h0, 8'h00, 0, 32'h0);
    addVec("c_wr_reg3",   1'b0, BASE + 32'h0C, 4'b1111, 32'h00000003, 2, 1, 32'h0, 8'h00, 3, 32'h0);
    addVec("c_rd_mask",   1'b1, BASE + 32'h20, 4'b1111, 32'h0,        2, 1, 32'h9, 8'h00, 0, 32'h0);
    addVec("c_rd_shadow", 1'b1, BASE + 32'h00, 4'b1111, 32'h0,        2, 1, 32'h1, 8'h00, 3, 32'h0);
    addVec("c_commit",    1'b0, BASE + 32'h20, 4'b0000, 32'h0,        2, 1, 32'h0, 8'h09, 0, 32'h1);
    addVec("c_rd_mask0",  1'b1, BASE + 32'h20, 4'b1111, 32'h0,        2, 1, 32'h0, 8'h00, 3, 32'h3);
    addVec("c_unmapped",  1'b1, BASE + 32'hFC, 4'b1111, 32'h0,        2, 1, 32'h0, 8'h00, 0, 32'h1);
    addVec("c_outside",   1'b1, HIGH + 32'h1,  4'b1111, 32'h0,        2, 0, 32'h0, 8'h00, 3, 32'h3);
`else
    addVec("wr_full",     1'b0, BASE + 32'h04, 4'b1111, 32'hDEADBEEF, 2, 1, 32'h0,        8'h02, 1, 32'hDEADBEEF);
    addVec("wr_lane3",    1'b0, BASE + 32'h04, 4'b0001, 32'h000000AA, 2, 1, 32'h0,        8'h02, 1, 32'hDEADBEAA);
    addVec("rd_reg1",     1'b1, BASE + 32'h04, 4'b1111, 32'h0,        2, 1, 32'hDEADBEAA, 8'h00, 1, 32'hDEADBEAA);
    addVec("rd_held",     1'b1, BASE + 32'h04, 4'b1111, 32'h0,        5, 1, 32'hDEADBEAA, 8'h00, 1, 32'hDEADBEAA);
    addVec("rd_unmapped", 1'b1, BASE + 32'hFC, 4'b1111, 32'h0,        2, 1, 32'h0,        8'h00, 0, 32'h0);
    addVec("wr_unmapped", 1'b0, BASE + 32'hFC, 4'b1111, 32'hFFFFFFFF, 2, 1, 32'h0,        8'h00, 7, 32'h0);
    addVec("rd_outside",  1'b1, HIGH + 32'h1,  4'b1111, 32'h0,        2, 0, 32'h0,        8'h00, 1, 32'hDEADBEAA);
    addVec("wr_outside",  1'b0, HIGH + 32'h1,  4'b1111, 32'hFFFFFFFF, 2, 0, 32'h0,        8'h00, 0, 32'h0);
    addVec("wr_be_none",  1'b0, BASE + 32'h08, 4'b0000, 32'hFFFFFFFF, 2, 1, 32'h0,        8'h00, 2, 32'h0);
    addVec("wr_lanes02",  1'b0, BASE + 32'h1C, 4'b1010, 32'h12345678, 2, 1, 32'h0,        8'h80, 7, 32'h12005600);
    addVec("rd_reg7",     1'b1, BASE + 32'h1C, 4'b1111, 32'h0,        2, 1, 32'h12005600, 8'h00, 7, 32'h12005600);
    addVec("rd_commit",   1'b1, BASE + 32'h20, 4'b1111, 32'h0,        2, 1, 32'h0,        8'h00, 1, 32'hDEADBEAA);
`endif

    repeat (2) @(negedge OPB_Clk);
    checkOutput("reset.ack", 32'(Sl_xferAck), 32'h0);
    checkOutput("reset.dbus", Sl_DBus, 32'h0);
    checkOutput("reset.upd", 32'(user_update), 32'h0);
    for (int w = 0; w < 8; w++)
      checkOutput($sformatf("reset.word%0d", w), user_data_out[32*w +: 32], 32'h0);
    OPB_Rst = 1'b1;
    @(negedge OPB_Clk);

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].rnw, vecs[n].addr, vecs[n].be, vecs[n].data, vecs[n].hold);
      checkOutput($sformatf("%s.ack", vecs[n].name), 32'(ack_cnt), 32'(vecs[n].exp_ack));
      checkOutput($sformatf("%s.rdata", vecs[n].name), rd_data, vecs[n].exp_rd);
      checkOutput($sformatf("%s.dbus_idle", vecs[n].name), 32'(dbus_bad), 32'h0);
      checkOutput($sformatf("%s.upd", vecs[n].name), 32'(upd_at2), 32'(vecs[n].exp_upd));
      checkOutput($sformatf("%s.upd_other", vecs[n].name), 32'(upd_other), 32'h0);
      checkOutput($sformatf("%s.word", vecs[n].name), user_data_out[32*vecs[n].word +: 32], vecs[n].exp_word);
    end

    // Reset lands in the middle of a write's ACK cycle.
    OPB_RNW    = 1'b0;
    OPB_ABus   = BASE + 32'h04;
    OPB_BE     = 4'b1111;
    OPB_DBus   = 32'h12345678;
    OPB_select = 1'b1;
    @(negedge OPB_Clk);
    checkOutput("rst_abort.pre_ack", 32'(Sl_xferAck), 32'h1);
    OPB_Rst = 1'b0;
    #1;
    checkOutput("rst_abort.ack", 32'(Sl_xferAck), 32'h0);
    OPB_select = 1'b0;
    OPB_ABus   = '0;
    OPB_DBus   = '0;
    OPB_BE     = '0;
    @(negedge OPB_Clk);
    checkOutput("rst_abort.upd", 32'(user_update), 32'h0);
    checkOutput("rst_abort.word1", user_data_out[63:32], 32'h0);
    OPB_Rst = 1'b1;
    @(negedge OPB_Clk);
    checkOutput("rst_abort.post_ack", 32'(Sl_xferAck), 32'h0);
    checkOutput("rst_abort.post_upd", 32'(user_update), 32'h0);
    checkOutput("rst_abort.post_word1", user_data_out[63:32], 32'h0);

    applyStimulus(1'b1, BASE + 32'h04, 4'b1111, 32'h0, 2);
    checkOutput("after_rst.ack", 32'(ack_cnt), 32'h1);
    checkOutput("after_rst.rdata", rd_data, 32'h0);
    checkOutput("after_rst.dbus_idle", 32'(dbus_bad), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/opb_register_bank.md
OPB_REGISTER_BANK -- requirements
Module: opb_register_bank

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h0108F000, meaning the first byte address of the decode window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h0108F0FF, meaning the last byte address of the decode window.
REQ-003 SHALL have parameter C_NUM_REGS, default 8, legal range 1..32, meaning the number of 32-bit software-to-fabric registers.
REQ-004 SHALL have parameter C_RESET_VAL, default 32'h00000000, meaning the value every register takes at reset.
REQ-005 SHALL use one clock, OPB_Clk, and an asynchronous, active-low reset, OPB_Rst; both SHALL be listed first and no other clock SHALL exist.
REQ-006 OPB_Clk  in  1  sole clock; all state is updated on the rising edge.
REQ-007 OPB_Rst  in  1  asynchronous active-low reset.
REQ-008 OPB_ABus in [0:31], OPB_BE in [0:3], OPB_DBus in [0:31], OPB_RNW in 1 (1 = read), OPB_select in 1, OPB_seqAddr in 1 (ignored).
REQ-009 Sl_DBus out [0:31], read data; Sl_xferAck out 1, transfer acknowledge; Sl_errAck, Sl_retry and Sl_toutSup out 1, each tied to 0.
REQ-010 user_data_out out [32*C_NUM_REGS-1:0]; register i SHALL drive bits [32*i+31:32*i].
REQ-011 user_update out [C_NUM_REGS-1:0]; bit i SHALL pulse for one cycle when user_data_out word i takes a new value.

Function
REQ-012 Register i SHALL decode at C_BASEADDR+4*i; OPB bit 0 SHALL map to user bit 31, and OPB_BE[0] SHALL qualify user bits [31:24].
REQ-013 The FSM SHALL have the states IDLE, ACK and DONE.
REQ-014 In IDLE, if OPB_select=1 and OPB_ABus is within [C_BASEADDR, C_HIGHADDR], the FSM SHALL move to ACK; otherwise it SHALL stay in IDLE.
REQ-015 In ACK, Sl_xferAck SHALL be 1 for exactly that one cycle, and the FSM SHALL then move to DONE.
REQ-016 In DONE, the FSM SHALL stay while OPB_select=1 and SHALL return to IDLE when OPB_select=0; a held select SHALL never produce a second acknowledge.
REQ-017 For a read, Sl_DBus SHALL be registered and valid during the ACK cycle, and SHALL be 0 in every other cycle.
REQ-018 For a write, the merged value SHALL be captured at the edge that ends ACK; only bytes whose BE bit is 1 SHALL change.
REQ-019 An address that is inside the window but not mapped to a register SHALL be acknowledged; a read SHALL return 0, and a write SHALL be ignored.
REQ-020 A write with OPB_BE=4'b0000 SHALL be acknowledged, SHALL change nothing and SHALL not pulse user_update.
REQ-021 Without commit mode, a write to register i SHALL drive user_data_out word i and pulse user_update[i] in the cycle after ACK, i.e. 2 cycles after select is sampled.
REQ-022 A read of register i SHALL return the register's current value, which is the shadow value when commit mode is compiled in.

Reset
REQ-023 While OPB_Rst=0: the FSM SHALL be IDLE, Sl_xferAck=0, Sl_DBus=0, every register and shadow SHALL equal C_RESET_VAL, user_update=0 and the dirty mask=0.
REQ-024 Reset asserted in ACK or DONE SHALL abort the transfer immediately, with no acknowledge and no write applied.
REQ-025 After reset is released, the first transfer SHALL be accepted from IDLE.

Configuration
REQ-026 With OPB_REGBANK_COMMIT_EN defined, writes SHALL update shadow registers and set dirty bit i, and user_data_out SHALL stay unchanged.
REQ-027 With OPB_REGBANK_COMMIT_EN defined, address C_BASEADDR+4*C_NUM_REGS SHALL be the commit register.
REQ-028 Any write to the commit register, with any BE, SHALL copy every dirty shadow to its output in the same cycle, pulse the matching user_update bits together, and clear the dirty mask.
REQ-029 A read of the commit register SHALL return the dirty mask, zero-extended to 32 bits.
REQ-030 Without OPB_REGBANK_COMMIT_EN, there SHALL be no shadows and no dirty mask, and the commit address SHALL behave as unmapped (REQ-019).

Structure
REQ-031 Package opb_regbank_pkg SHALL hold the FSM state enum, the bus width constant (32), the byte-lane count (4) and the commit offset function.
REQ-032 Sub-module opb_regbank_slot SHALL implement one register with byte-enable merge, the optional shadow and the dirty bit, and SHALL be instantiated C_NUM_REGS times.

Verification
REQ-033 Write 32'hDEADBEEF to base+0x4 with BE=1111 -> one Sl_xferAck; user_data_out word1=DEADBEEF and user_update=8'h02 for one cycle, 2 cycles after select.
REQ-034 Write 32'h000000AA to base+0x4 with BE=0001 over DEADBEEF, then read it -> Sl_DBus=DEADBEAA during ACK, and 0 in other cycles.
REQ-035 Hold select for 5 cycles -> exactly one xferAck; access base+0xFC -> acked, read 0; access C_HIGHADDR+1 -> no ack.
REQ-036 Pulse OPB_Rst low during ACK of a write of 32'h12345678 -> no ack, the register stays C_RESET_VAL and the FSM is in IDLE.
REQ-037 With COMMIT_EN: write reg0=1 and reg3=3, then read commit -> 32'h9 and outputs unchanged; write commit -> word0=1, word3=3, user_update=8'h09 in one cycle, and the mask reads 0.
